// File: rtl/id_branch_stage_pkg.sv
// Shared widths, MIPS branch/jump encodings and bus layouts for the ID stage.
package id_branch_stage_pkg;

    localparam int BR_BUS_WD       = 34;
    localparam int FS_TO_DS_BUS_WD = 98;
    localparam int DS_TO_ES_BUS_WD = 162;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    typedef struct packed {
        logic        fs_ex;
        logic        fs_bd;
        logic [31:0] badvaddr;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    typedef enum logic [1:0] {
        TGT_BRANCH,
        TGT_JUMP,
        TGT_REG
    } tgt_sel_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_branch_stage_if.sv
// Signals between the ID stage and its neighbours (IF, register file, hazard unit, EX, WB).
interface id_branch_stage_if;
    import id_branch_stage_pkg::*;

    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       ds_is_branch;
    logic [4:0]                 rf_raddr1;
    logic [4:0]                 rf_raddr2;
    logic [31:0]                rf_rdata1;
    logic [31:0]                rf_rdata2;
    logic                       operand_stall;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       ws_ex;
    logic                       ws_eret;

    modport slave (
        input  fs_to_ds_valid, fs_to_ds_bus, rf_rdata1, rf_rdata2,
               operand_stall, es_allowin, ws_ex, ws_eret,
        output ds_allowin, br_bus, ds_is_branch, rf_raddr1, rf_raddr2,
               ds_to_es_valid, ds_to_es_bus
    );

    modport master (
        output fs_to_ds_valid, fs_to_ds_bus, rf_rdata1, rf_rdata2,
               operand_stall, es_allowin, ws_ex, ws_eret,
        input  ds_allowin, br_bus, ds_is_branch, rf_raddr1, rf_raddr2,
               ds_to_es_valid, ds_to_es_bus
    );

endinterface

// File: rtl/id_branch_stage_branch_cond.sv
// Combinational branch/jump decode, condition evaluation and target generation.
module branch_cond
    import id_branch_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        is_branch,
    output logic        taken,
    output logic [31:0] target
);

    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic        rs_neg;
    logic        rs_zero;
    logic        cond;
    tgt_sel_e    tgt_sel;

    always_comb begin
        opcode    = inst[31:26];
        rt_field  = inst[20:16];
        funct     = inst[5:0];
        pc_plus4  = pc + 32'd4;
        // Signed compare against zero reduces to sign bit and zero test.
        rs_neg    = rs_value[31];
        rs_zero   = (rs_value == 32'd0);
        is_branch = 1'b0;
        cond      = 1'b0;
        tgt_sel   = TGT_BRANCH;

        case (opcode)
            OP_BEQ:  begin is_branch = 1'b1; cond = (rs_value == rt_value); end
            OP_BNE:  begin is_branch = 1'b1; cond = (rs_value != rt_value); end
            OP_BLEZ: begin is_branch = 1'b1; cond = rs_neg || rs_zero;      end
            OP_BGTZ: begin is_branch = 1'b1; cond = !rs_neg && !rs_zero;    end
            OP_REGIMM: begin
                case (rt_field)
                    RT_BLTZ, RT_BLTZAL: begin is_branch = 1'b1; cond = rs_neg;  end
                    RT_BGEZ, RT_BGEZAL: begin is_branch = 1'b1; cond = !rs_neg; end
                    default: ;
                endcase
            end
            OP_J, OP_JAL: begin
                is_branch = 1'b1;
                cond      = 1'b1;
                tgt_sel   = TGT_JUMP;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    is_branch = 1'b1;
                    cond      = 1'b1;
                    tgt_sel   = TGT_REG;
                end
            end
            default: ;
        endcase

        case (tgt_sel)
            TGT_JUMP: target = {pc_plus4[31:28], inst[25:0], 2'b00};
            TGT_REG:  target = rs_value;
            default:  target = pc_plus4 + branch_offset(inst[15:0]);
        endcase

        taken = is_branch && cond;
    end

endmodule

// File: rtl/id_branch_stage.sv
// ID pipeline stage: one instruction register, branch resolution back to IF,
// operand attachment and flush handling toward EX.
module id_branch_stage
    import id_branch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    id_branch_stage_if.slave  io
);

    logic      ds_valid_q, ds_valid_d;
    fs_to_ds_t ds_bus_q, ds_bus_d;

    logic        flush;
    logic        ds_ready_go;
    logic        ds_allowin;
    logic        bc_is_branch;
    logic        bc_taken;
    logic [31:0] bc_target;
    logic        br_stall;
    logic        br_taken;

    branch_cond u_branch_cond (
        .inst      (ds_bus_q.inst),
        .pc        (ds_bus_q.pc),
        .rs_value  (io.rf_rdata1),
        .rt_value  (io.rf_rdata2),
        .is_branch (bc_is_branch),
        .taken     (bc_taken),
        .target    (bc_target)
    );

    always_comb begin
        flush       = io.ws_ex || io.ws_eret;
        ds_ready_go = !io.operand_stall;
        ds_allowin  = !ds_valid_q || (ds_ready_go && io.es_allowin);

        ds_valid_d = ds_valid_q;
        ds_bus_d   = ds_bus_q;
        if (ds_allowin) begin
            ds_valid_d = io.fs_to_ds_valid;
        end
        // A flush always empties the stage, even if IF is handing over.
        if (flush) begin
            ds_valid_d = 1'b0;
        end
        if (io.fs_to_ds_valid && ds_allowin) begin
            ds_bus_d = io.fs_to_ds_bus;
        end

        br_stall = ds_valid_q && bc_is_branch && io.operand_stall && !flush;
        br_taken = ds_valid_q && bc_taken && ds_ready_go && !ds_bus_q.fs_ex && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_bus_q   <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_bus_q   <= ds_bus_d;
        end
    end

    // Target is forced to zero when not redirecting so IF never sees stale addresses.
    assign io.br_bus         = {br_stall, br_taken, (br_taken ? bc_target : 32'd0)};
    assign io.ds_allowin     = ds_allowin;
    assign io.ds_is_branch   = ds_valid_q && bc_is_branch;
    assign io.rf_raddr1      = ds_bus_q.inst[25:21];
    assign io.rf_raddr2      = ds_bus_q.inst[20:16];
    assign io.ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;
    assign io.ds_to_es_bus   = {ds_bus_q, io.rf_rdata1, io.rf_rdata2};

endmodule
